// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scanner.
// A nibble above 9 has no segment code and is blanked instead of shown.
package seg_pkg;

   localparam int         NDIG    = 4;
   localparam logic [3:0] DIG_OFF = 4'b1111;
   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd(input logic [3:0] nib);
      return (nib <= BCD_MAX);
   endfunction

endpackage

// File: rtl/seg_scan_tick_div.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled and strobes o_wrap on the last count.
// o_wrap is combinational and already qualified by i_en, so callers can act on it directly.
module tick_div #(
   parameter int DIV = 50000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   output logic [$clog2(DIV)-1:0]  o_cnt,
   output logic                    o_wrap
);

   localparam int              CW   = $clog2(DIV);
   localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Slot counter; holds its value while disabled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_cnt  = r_cnt;
   assign o_wrap = i_en && (r_cnt == LAST);

endmodule

// File: rtl/seg_scan.sv
// Four-digit time-multiplexed 7-segment scanner with a frame-consistent input shadow,
// leading-zero suppression, invalid-digit blanking and per-slot anti-ghost blanking.
import seg_pkg::*;

module seg_scan #(
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic        lz_blank,
   output logic [3:0]  bcd_out,
   output logic [3:0]  dig_sel,
   output logic        dp_out,
   output logic        frame_tick
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(NDIG);

   logic [CW-1:0] w_cnt;
   logic          w_wrap;
   logic          w_frame_wrap;

   logic [IW-1:0] r_idx;
   logic [15:0]   r_shadow;
   logic [3:0]    r_shadow_dp;
   logic          r_shadow_lz;
   logic          r_primed;

   logic [3:0]    r_bcd;
   logic [3:0]    r_sel;
   logic          r_dp;
   logic          r_frame_tick;

   logic [3:0]    w_nib;
   logic          w_dp;
   logic          w_higher_zero;
   logic          w_suppress;
   logic          w_invalid;
   logic          w_in_blank;
   logic [3:0]    w_bcd_nxt;
   logic [3:0]    w_sel_nxt;
   logic          w_dp_nxt;

   tick_div #(.DIV(DIV)) u_div (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_en   (en),
      .o_cnt  (w_cnt),
      .o_wrap (w_wrap)
   );

   assign w_frame_wrap = w_wrap && (r_idx == IW'(NDIG - 1));

   // Digit index advances once per slot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if (w_wrap) begin
         r_idx <= r_idx + IW'(1);
      end
   end

   // Shadow loads on the first enabled cycle, then only at frame boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow    <= 16'h0000;
         r_shadow_dp <= 4'b0000;
         r_shadow_lz <= 1'b0;
         r_primed    <= 1'b0;
      end else if (en && (!r_primed || w_frame_wrap)) begin
         r_shadow    <= digits;
         r_shadow_dp <= dp_mask;
         r_shadow_lz <= lz_blank;
         r_primed    <= 1'b1;
      end
   end

   assign w_nib      = r_shadow[{r_idx, 2'b00} +: 4];
   assign w_dp       = r_shadow_dp[r_idx];
   assign w_invalid  = !is_bcd(w_nib);
   assign w_in_blank = (w_cnt < CW'(BLANK));

   // True when every nibble above the current slot is zero.
   always_comb begin
      w_higher_zero = 1'b1;
      case (r_idx)
         2'd0:    w_higher_zero = (r_shadow[15:4]  == 12'h000);
         2'd1:    w_higher_zero = (r_shadow[15:8]  == 8'h00);
         2'd2:    w_higher_zero = (r_shadow[15:12] == 4'h0);
         default: w_higher_zero = 1'b1;
      endcase
   end

   // A lit decimal point keeps an otherwise suppressed zero visible.
   assign w_suppress = r_shadow_lz && (w_nib == 4'd0) && w_higher_zero &&
                       (r_idx != 2'd0) && !w_dp;

   // Next-cycle display values for the current slot.
   always_comb begin
      w_bcd_nxt = w_nib;
      w_sel_nxt = DIG_OFF;
      w_dp_nxt  = 1'b0;
      if (!en) begin
         w_sel_nxt = DIG_OFF;
      end else if (w_in_blank) begin
         w_sel_nxt = DIG_OFF;
      end else if (w_invalid || w_suppress) begin
         w_bcd_nxt = 4'd0;
      end else begin
         w_sel_nxt = ~(4'b0001 << r_idx);
         w_dp_nxt  = w_dp;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcd        <= 4'd0;
         r_sel        <= DIG_OFF;
         r_dp         <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_bcd        <= w_bcd_nxt;
         r_sel        <= w_sel_nxt;
         r_dp         <= w_dp_nxt;
         r_frame_tick <= w_frame_wrap;
      end
   end

   assign bcd_out    = r_bcd;
   assign dig_sel    = r_sel;
   assign dp_out     = r_dp;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIV=8, BLANK=2; sample k after enabling reflects
// scan state k (slot k/8, count k%8) because outputs carry one cycle of latency.
module tb_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        lz_blank;
   logic [3:0]  bcd_out;
   logic [3:0]  dig_sel;
   logic        dp_out;
   logic        frame_tick;

   int n_pass  = 0;
   int n_total = 0;

   seg_scan #(.DIV(8), .BLANK(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .lz_blank   (lz_blank),
      .bcd_out    (bcd_out),
      .dig_sel    (dig_sel),
      .dp_out     (dp_out),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reset, load inputs, then enable so that the next tick shows state 0.
   task automatic restart(input logic [15:0] w, input logic [3:0] m, input logic z);
      rst = 1'b1; en = 1'b0; digits = w; dp_mask = m; lz_blank = z;
      tick; tick;
      rst = 1'b0;
      tick;
      en = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; en = 1'b0; digits = 16'h1234; dp_mask = 4'b0000; lz_blank = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (dig_sel !== 4'b1111 || bcd_out !== 4'd0 || dp_out !== 1'b0 || frame_tick !== 1'b0)
         $display("FAIL reset_values sel=%b bcd=%h dp=%b ft=%b required 1111/0/0/0",
                  dig_sel, bcd_out, dp_out, frame_tick);
      else n_pass++;
   endtask

   task automatic test_basic;
      logic [3:0] sel_t[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] bcd_t[4] = '{4'd4, 4'd3, 4'd2, 4'd1};
      logic [3:0] es;
      logic       eft;
      restart(16'h1234, 4'b0000, 1'b0);
      for (int c = 0; c < 64; c++) begin
         int s, ct;
         tick;
         s = (c / 8) % 4; ct = c % 8;
         es = (ct < 2) ? 4'b1111 : sel_t[s];
         n_total++;
         if (dig_sel !== es || dp_out !== 1'b0 || (c > 0 && bcd_out !== bcd_t[s]))
            $display("FAIL basic_scan c=%0d sel=%b bcd=%h dp=%b required sel=%b bcd=%h dp=0",
                     c, dig_sel, bcd_out, dp_out, es, bcd_t[s]);
         else n_pass++;
         eft = (c % 32 == 31);
         n_total++;
         if (frame_tick !== eft)
            $display("FAIL frame_tick c=%0d got=%b required=%b", c, frame_tick, eft);
         else n_pass++;
      end
   endtask

   task automatic test_lz_blank;
      logic [15:0] w_t[4] = '{16'h0045, 16'h0000, 16'h0405, 16'h0005};
      logic [3:0]  m_t[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
      logic [3:0]  sel_t[16] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111,
                                 4'b1110, 4'b1111, 4'b1111, 4'b1111,
                                 4'b1110, 4'b1101, 4'b1011, 4'b1111,
                                 4'b1110, 4'b1111, 4'b1011, 4'b1111};
      logic [3:0]  bcd_t[16] = '{4'd5, 4'd4, 4'd0, 4'd0,
                                 4'd0, 4'd0, 4'd0, 4'd0,
                                 4'd5, 4'd0, 4'd4, 4'd0,
                                 4'd5, 4'd0, 4'd0, 4'd0};
      logic        dp_t[16]  = '{1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         restart(w_t[k], m_t[k], 1'b1);
         for (int c = 0; c < 32; c++) begin
            int e;
            tick;
            e = k * 4 + c / 8;
            n_total++;
            if (c % 8 < 2) begin
               if (dig_sel !== 4'b1111 || dp_out !== 1'b0)
                  $display("FAIL lz_ghost case=%0d c=%0d sel=%b dp=%b required 1111/0",
                           k, c, dig_sel, dp_out);
               else n_pass++;
            end else begin
               if (dig_sel !== sel_t[e] || bcd_out !== bcd_t[e] || dp_out !== dp_t[e])
                  $display("FAIL lz_slot case=%0d c=%0d sel=%b bcd=%h dp=%b required %b/%h/%b",
                           k, c, dig_sel, bcd_out, dp_out, sel_t[e], bcd_t[e], dp_t[e]);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_invalid;
      logic [3:0] sel_t[4] = '{4'b1110, 4'b1111, 4'b1011, 4'b0111};
      logic [3:0] bcd_t[4] = '{4'd4, 4'd0, 4'd2, 4'd1};
      restart(16'h12A4, 4'b0000, 1'b0);
      for (int c = 0; c < 32; c++) begin
         int s;
         tick;
         s = c / 8;
         if (c % 8 >= 2) begin
            n_total++;
            if (dig_sel !== sel_t[s] || bcd_out !== bcd_t[s] || dp_out !== 1'b0)
               $display("FAIL invalid_digit c=%0d sel=%b bcd=%h dp=%b required %b/%h/0",
                        c, dig_sel, bcd_out, dp_out, sel_t[s], bcd_t[s]);
            else n_pass++;
         end
         if (c == 9) begin
            n_total++;
            if (bcd_out !== 4'hA || dig_sel !== 4'b1111)
               $display("FAIL invalid_preset sel=%b bcd=%h required 1111/a", dig_sel, bcd_out);
            else n_pass++;
         end
      end
   endtask

   task automatic test_frame_consistency;
      logic [3:0] sel_t[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] bcd_t[8] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
      restart(16'h1234, 4'b0000, 1'b0);
      for (int c = 0; c < 64; c++) begin
         int s;
         tick;
         s = c / 8;
         if (c % 8 >= 2) begin
            n_total++;
            if (dig_sel !== sel_t[s % 4] || bcd_out !== bcd_t[s])
               $display("FAIL frame_consistency c=%0d sel=%b bcd=%h required %b/%h",
                        c, dig_sel, bcd_out, sel_t[s % 4], bcd_t[s]);
            else n_pass++;
         end
         if (c == 10) digits = 16'h9876;
      end
   endtask

   task automatic test_enable_reset;
      logic [3:0] sel_t[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] bcd_t[4] = '{4'd4, 4'd3, 4'd2, 4'd1};
      restart(16'h1234, 4'b0000, 1'b0);
      for (int c = 0; c < 20; c++) tick;
      n_total++;
      if (dig_sel !== 4'b1011 || bcd_out !== 4'd2)
         $display("FAIL pre_disable sel=%b bcd=%h required 1011/2", dig_sel, bcd_out);
      else n_pass++;
      en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick;
         n_total++;
         if (dig_sel !== 4'b1111 || dp_out !== 1'b0 || frame_tick !== 1'b0)
            $display("FAIL disabled k=%0d sel=%b dp=%b ft=%b required 1111/0/0",
                     k, dig_sel, dp_out, frame_tick);
         else n_pass++;
      end
      en = 1'b1;
      for (int j = 0; j < 12; j++) begin
         int st, s, ct;
         logic [3:0] es;
         tick;
         st = 20 + j; s = st / 8; ct = st % 8;
         es = (ct < 2) ? 4'b1111 : sel_t[s];
         n_total++;
         if (dig_sel !== es || (ct >= 2 && bcd_out !== bcd_t[s]) || frame_tick !== (st == 31))
            $display("FAIL resume j=%0d sel=%b bcd=%h ft=%b required sel=%b bcd=%h ft=%b",
                     j, dig_sel, bcd_out, frame_tick, es, bcd_t[s], (st == 31));
         else n_pass++;
      end
      tick; tick; tick;
      #3;
      rst = 1'b1;
      #1;
      n_total++;
      if (dig_sel !== 4'b1111 || bcd_out !== 4'd0 || dp_out !== 1'b0 || frame_tick !== 1'b0)
         $display("FAIL async_reset sel=%b bcd=%h dp=%b ft=%b required 1111/0/0/0",
                  dig_sel, bcd_out, dp_out, frame_tick);
      else n_pass++;
      tick;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         int s, ct;
         logic [3:0] es;
         tick;
         s = c / 8; ct = c % 8;
         es = (ct < 2) ? 4'b1111 : sel_t[s];
         n_total++;
         if (dig_sel !== es || (c > 0 && bcd_out !== bcd_t[s]))
            $display("FAIL post_reset c=%0d sel=%b bcd=%h required sel=%b bcd=%h",
                     c, dig_sel, bcd_out, es, bcd_t[s]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_lz_blank;
      test_invalid;
      test_frame_consistency;
      test_enable_reset;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
Four-digit time-multiplexed scanner for the 7-segment display path. It holds a 4-digit BCD word and presents one nibble at a time on bcd_out, which feeds the BCD-to-segment decoder. It drives the matching active-low digit-select line and a decimal point. It also handles leading-zero suppression, invalid-digit blanking, inter-digit ghost blanking and frame-consistent sampling of the input word.

Parameters:
DIV, 50000, clock cycles per digit slot (must be ≥ 2 and > BLANK)
BLANK, 16, dead cycles at the start of each slot with all digits off (anti-ghosting)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; low freezes the scan and turns the display off
digits  input  16  four BCD digits; [3:0]=digit0 (least significant) … [15:12]=digit3
dp_mask  input  4  decimal point per digit, bit i = digit i, 1 = lit
lz_blank  input  1  1 = suppress leading zeros
bcd_out  output  4  nibble for the segment decoder
dig_sel  output  4  digit enables, active-low, bit i = digit i
dp_out  output  1  decimal point for the current slot, 1 = lit
frame_tick  output  1  one-cycle pulse at each frame wrap

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - Internal: cnt=0, idx=0, shadow=0, primed=0.
  - Outputs: bcd_out=0, dig_sel=4'b1111, dp_out=0, frame_tick=0.
  - Reset asserted mid-frame takes effect immediately; outputs go to reset values with no partial slot.
- Prescaler cnt:
  - Counts 0..DIV-1 while en=1.
  - At DIV-1 it wraps to 0 and idx advances 0→1→2→3→0.
- Shadow register:
  - Loads digits, dp_mask and lz_blank together on the first en=1 cycle after reset (primed←1).
  - Afterwards it loads only on the wrap cycle (cnt=DIV-1, idx=3).
  - Input changes mid-frame never appear until the next frame.
- frame_tick: registered. It is 1 in the cycle after the wrap cycle, otherwise 0.
- Outputs are registered. Values computed from (cnt, idx, shadow) in cycle t appear in cycle t+1, so there is 1 cycle of latency. They are glitch-free.
- Slot i, with cnt < BLANK:
  - dig_sel=1111, dp_out=0.
  - bcd_out = nibble i (presetting the decoder).
- Slot i, with cnt ≥ BLANK:
  - dig_sel = ~(1<<i), bcd_out = shadow nibble i, dp_out = shadow dp i.
  - Exception: the slot is blanked (dig_sel=1111, dp_out=0, bcd_out=0) if either:
    - nibble i > 9 (invalid BCD; the decoder has no valid code for it), or
    - lz_blank=1, nibble i = 0, all higher nibbles = 0, and i≠0.
  - Digit 0 is never zero-suppressed. A lit dp keeps a zero-suppressed digit visible (0 shown).
- en=0:
  - cnt and idx hold; shadow does not load.
  - Next cycle: dig_sel=1111, dp_out=0, frame_tick=0.
  - When en returns to 1, scanning resumes from the held cnt/idx.
- Simultaneous wrap and en falling in the same cycle: en has priority; no advance and no load.

Decomposition:
- Shared package seg_pkg:
  - NDIG=4, DIG_OFF=4'b1111, BCD_MAX=4'd9.
  - Function is_bcd(nibble).
- One natural sub-module, tick_div: a DIV prescaler giving cnt and a wrap strobe, with asynchronous active-high reset and enable.
- Blanking, suppression and output registering stay in seg_scan.

Test Plan:
(All with DIV=8, BLANK=2.)
1. Basic scan: digits=16'h1234, dp_mask=0, lz_blank=0, en=1 → per 8-cycle slot, 2 cycles of dig_sel=1111, then 6 cycles of:
   - 1110/bcd 4,
   - 1101/3,
   - 1011/2,
   - 0111/1.

   frame_tick pulses once every 32 cycles.
2. Leading-zero suppression: digits=16'h0045, lz_blank=1 → digits 3 and 2 stay 1111, digits 1/0 show 4/5. digits=16'h0000 → only digit 0 lit, showing 0. digits=16'h0405 → digit 3 blank, digit 2 lit showing 4, digit 1 lit showing 0, digit 0 lit showing 5. dp_mask=4'b0100 with 16'h0005 → digit 2 lit showing 0 with dp_out=1.
3. Invalid digit: digits=16'h12A4 → slot 1 dig_sel=1111, bcd_out=0. Other digits show normally.
4. Frame consistency: change digits from 16'h1234 to 16'h9876 during slot 1 → the rest of the frame still shows 2/1. 9876 appears starting at slot 0 after frame_tick.
5. Enable/reset: deassert en during slot 2 → next cycle dig_sel=1111, and cnt/idx hold for 20 cycles. Re-enable → slot 2 resumes at the same cnt. Assert rst asynchronously mid-slot → outputs immediately at reset values. After release, the first frame starts at slot 0.
